fpdiv_iterative_unit: RTL and testbench



---
 rtl/fpdiv_iterative_unit_if.sv | 21 ++
 rtl/fpdiv_iterative_unit.sv | 189 ++++++++++++++++++
 tb/tb_fpdiv_iterative_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_iterative_unit_if.sv
// Handshake bundle for fpdiv_iterative_unit: operand side (a, b, in_valid/in_ready)
// and result side (p, out_valid/out_ready). slave = divider, master = its user.
interface fpdiv_iterative_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, p, out_valid
  );

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, p, out_valid
  );
endinterface

// File: rtl/fpdiv_iterative_unit.sv
// Iterative binary32 divider: restoring shift-subtract, one quotient bit/cycle.
// Ports: clk, rst (sync, active-high), bus (slave: a, b, in_valid/in_ready,
// p, out_valid/out_ready). FPDIV_ROUND_NEAREST_EN selects RNE, else truncate.
module fpdiv_iterative_unit (
  input  logic               clk,
  input  logic               rst,
  fpdiv_iterative_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [24:0]       rem_q;
  logic [23:0]       mb_q;
  logic [25:0]       q_q;
  logic [4:0]        cnt_q;
  logic signed [9:0] e_pre_q;
  logic              sp_q;
  logic              spec_q;
  logic [31:0]       spec_val_q;
  logic [31:0]       p_q;

  // operand decode (only meaningful in IDLE)
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        sp;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic        accept;

  assign ea = bus.a[30:23];
  assign eb = bus.b[30:23];
  assign fa = bus.a[22:0];
  assign fb = bus.b[22:0];
  assign sp = bus.a[31] ^ bus.b[31];

  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'h0);

  // order matters: 0/0 and inf/inf must be caught before x/0 and inf/x
  always_comb begin
    spec_hit = 1'b1;
    spec_val = {sp, 31'h0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_val = 32'h7FC0_0000;
    else if (b_zero || a_inf)
      spec_val = {sp, 8'hFF, 23'h0};
    else if (a_zero || b_inf)
      spec_val = {sp, 31'h0};
    else
      spec_hit = 1'b0;
  end

  assign accept = bus.in_valid && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = spec_hit ? NORM : DIVIDE;
      end
      DIVIDE: begin
        if (cnt_q == 5'd0)
          state_d = NORM;
      end
      NORM: state_d = DONE;
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // one restoring step; rem < 2*Mb, so the difference fits 24 bits
  logic        ge;
  logic [23:0] sub;
  logic [23:0] rem_nxt;

  assign ge      = rem_q >= {1'b0, mb_q};
  assign sub     = rem_q[23:0] - mb_q;
  assign rem_nxt = ge ? sub : rem_q[23:0];

  // normalise: quotient in [0.5, 2), q[25] marks the >= 1 case
  logic              lead;
  logic [24:0]       nq;
  logic [22:0]       frac;
  logic              guard_bit;
  logic              sticky_bit;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;
  logic [22:0]       frac_f;
  logic [31:0]       norm_res;
  logic              unused_lead;

  assign lead       = q_q[25];
  assign nq         = lead ? q_q[25:1] : q_q[24:0];
  assign frac       = nq[23:1];
  assign guard_bit  = nq[0];
  assign sticky_bit = (lead & q_q[0]) | (rem_q != 25'h0);
  assign e_n        = lead ? e_pre_q : e_pre_q - 10'sd1;
  assign unused_lead = nq[24];

`ifdef FPDIV_ROUND_NEAREST_EN
  logic        inc;
  logic [23:0] frac_sum;

  assign inc      = guard_bit & (sticky_bit | frac[0]);
  assign frac_sum = {1'b0, frac} + {23'h0, inc};
  // carry-out means mantissa rounded up to 2.0
  assign frac_f   = frac_sum[23] ? 23'h0 : frac_sum[22:0];
  assign e_r      = frac_sum[23] ? e_n + 10'sd1 : e_n;
`else
  logic unused_round;

  assign unused_round = guard_bit ^ sticky_bit;
  assign frac_f       = frac;
  assign e_r          = e_n;
`endif

  always_comb begin
    norm_res = {sp_q, e_r[7:0], frac_f};
    if (e_r >= 10'sd255)
      norm_res = {sp_q, 8'hFF, 23'h0};
    else if (e_r <= 10'sd0)
      norm_res = {sp_q, 31'h0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      mb_q       <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      e_pre_q    <= '0;
      sp_q       <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      p_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rem_q      <= {2'b01, fa};
            mb_q       <= {1'b1, fb};
            q_q        <= '0;
            cnt_q      <= 5'd25;
            e_pre_q    <= {2'b00, ea} - {2'b00, eb} + 10'sd127;
            sp_q       <= sp;
            spec_q     <= spec_hit;
            spec_val_q <= spec_val;
          end
        end
        DIVIDE: begin
          rem_q <= {rem_nxt, 1'b0};
          q_q   <= {q_q[24:0], ge};
          cnt_q <= cnt_q - 5'd1;
        end
        NORM: begin
          p_q <= spec_q ? spec_val_q : norm_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_fpdiv_iterative_unit.sv
// Directed self-checking bench for fpdiv_iterative_unit.
// Latency is counted in clock edges from the accepting edge (cycle 0).
module tb_fpdiv_iterative_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fpdiv_iterative_unit_if bus ();

  fpdiv_iterative_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FPDIV_ROUND_NEAREST_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.p !== 32'h0) begin
      failures++;
      $display("FAIL reset_p got=%h exp=%h", bus.p, 32'h0);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_normal();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vp [5];
    int lat;
    va[0] = 32'h40C00000; vb[0] = 32'h40000000; vp[0] = 32'h40400000;
    va[1] = 32'h3F800000; vb[1] = 32'h40400000; vp[1] = THIRD;
    va[2] = 32'h3FC00000; vb[2] = 32'hBF800000; vp[2] = 32'hBFC00000;
    va[3] = 32'hC1000000; vb[3] = 32'h3F000000; vp[3] = 32'hC1800000;
    va[4] = 32'h3F800000; vb[4] = 32'h3F800000; vp[4] = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 28) begin
        failures++;
        $display("FAIL normal_lat[%0d] got=%0d exp=28", i, lat);
      end
      checks++;
      if (bus.p !== vp[i]) begin
        failures++;
        $display("FAIL normal_p[%0d] got=%h exp=%h", i, bus.p, vp[i]);
      end
      release_out();
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL normal_in_ready[%0d] got=%b exp=1", i, bus.in_ready);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vp [5];
    int lat;
    va[0] = 32'h3F800000; vb[0] = 32'h00000000; vp[0] = 32'h7F800000;
    va[1] = 32'h00000000; vb[1] = 32'h00000000; vp[1] = 32'h7FC00000;
    va[2] = 32'hBF800000; vb[2] = 32'h7F800000; vp[2] = 32'h80000000;
    va[3] = 32'h7FC00001; vb[3] = 32'h3F800000; vp[3] = 32'h7FC00000;
    va[4] = 32'hFF800000; vb[4] = 32'h40000000; vp[4] = 32'hFF800000;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL special_lat[%0d] got=%0d exp=2", i, lat);
      end
      checks++;
      if (bus.p !== vp[i]) begin
        failures++;
        $display("FAIL special_p[%0d] got=%h exp=%h", i, bus.p, vp[i]);
      end
      release_out();
    end
  endtask

  task automatic test_range();
    int lat;
    issue(32'h7F000000, 32'h3E800000);
    wait_valid(lat);
    checks++;
    if (bus.p !== 32'h7F800000 || lat !== 28) begin
      failures++;
      $display("FAIL overflow got=%h lat=%0d exp=7f800000 lat=28", bus.p, lat);
    end
    release_out();
    issue(32'h00800000, 32'h7F000000);
    wait_valid(lat);
    checks++;
    if (bus.p !== 32'h00000000 || lat !== 28) begin
      failures++;
      $display("FAIL underflow got=%h lat=%0d exp=00000000 lat=28", bus.p, lat);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(32'h40C00000, 32'h40000000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.p !== 32'h40400000 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure[%0d] p=%h ov=%b ir=%b exp p=40400000 ov=1 ir=0",
                 i, bus.p, bus.out_valid, bus.in_ready);
      end
    end
    release_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_divide();
    int lat;
    issue(32'h3F800000, 32'h40400000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.p !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset ov=%b ir=%b p=%h exp ov=0 ir=1 p=00000000",
               bus.out_valid, bus.in_ready, bus.p);
    end
    issue(32'h40C00000, 32'h40000000);
    wait_valid(lat);
    checks++;
    if (bus.p !== 32'h40400000 || lat !== 28) begin
      failures++;
      $display("FAIL after_reset got=%h lat=%0d exp=40400000 lat=28", bus.p, lat);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    // producer holds in_valid while busy; it must be ignored until IDLE
    @(negedge clk);
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    wait_valid(lat);
    checks++;
    if (bus.p !== 32'h40400000 || lat !== 28) begin
      failures++;
      $display("FAIL b2b_first got=%h lat=%0d exp=40400000 lat=28", bus.p, lat);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (bus.p !== THIRD || lat !== 28) begin
      failures++;
      $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=28", bus.p, lat, THIRD);
    end
    release_out();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_backpressure();
    test_reset_mid_divide();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
